mem_arb_2432: RTL and testbench
===============================

Name: mem_arb_2432

Overview:
- Single-port memory sequencer for the 24-bit-instruction / 32-bit-data CPU core.
- Serialises each CPU step into an instruction fetch, then an optional data read or write, on one shared external memory bus.
- Pulses the core's clock enable once both accesses have completed.
- Sits between the CPU (iaddr/daddr/ram_rd/ram_wr/dout ports) and the unified program/data RAM.

Parameters:
- ADDR_W, 24, memory address width.
- DATA_W, 32, data bus width.
- INSTR_W, 24, instruction width, taken from i_mem_din[INSTR_W-1:0].
- MAX_WAIT, 255, cycles to wait for i_mem_ack before aborting an access (timeout).

Ports:
- i_clk  in  1  clock
- i_rstb  in  1  asynchronous active-low reset
- i_clk_en  in  1  system run enable; gates the start of a new CPU step
- i_cpu_iaddr  in  ADDR_W  CPU fetch address
- i_cpu_daddr  in  ADDR_W  CPU data address
- i_cpu_dout  in  DATA_W  CPU store data
- i_cpu_ram_rd  in  1  CPU load request
- i_cpu_ram_wr  in  1  CPU store request
- o_cpu_instr  out  INSTR_W  registered instruction presented to the CPU
- o_cpu_din  out  DATA_W  registered load data presented to the CPU
- o_cpu_clk_en  out  1  one-cycle CPU advance pulse
- o_mem_addr  out  ADDR_W  memory address
- o_mem_dout  out  DATA_W  memory write data
- o_mem_rd  out  1  memory read strobe
- o_mem_wr  out  1  memory write strobe
- i_mem_din  in  DATA_W  memory read data, valid with ack
- i_mem_ack  in  1  access complete; may be asserted in the same cycle as the strobe
- o_bus_err  out  1  sticky timeout flag

Behaviour:
- Reset is asynchronous, active-low on i_rstb; clock is i_clk.
- Reset values:
  - state = IDLE; all outputs 0.
  - Instruction and data registers 0; wait counter 0; o_bus_err 0.
- FSM states: IDLE, IFETCH, DACC, STEP.
  - IDLE: if i_clk_en -> IFETCH.
  - IFETCH: o_mem_rd=1, o_mem_addr=i_cpu_iaddr. On ack, capture i_mem_din[INSTR_W-1:0] into o_cpu_instr. Then -> DACC if (i_cpu_ram_rd | i_cpu_ram_wr), else -> STEP.
  - DACC: o_mem_addr=i_cpu_daddr.
    - Write: o_mem_wr=1, o_mem_dout=i_cpu_dout.
    - Read: o_mem_rd=1; on ack, capture i_mem_din into o_cpu_din.
    - On ack -> STEP.
  - STEP: o_cpu_clk_en=1 for exactly one cycle. Then -> IFETCH if i_clk_en, else -> IDLE.
- Request selection in DACC: the rd/wr decision is taken from the CPU inputs while in DACC.
  - CPU inputs are stable while o_cpu_clk_en is low.
  - The instruction is fetched first because, in two-stage mode, the data request decode depends on the presented instruction.
- Strobes and o_mem_addr/o_mem_dout are decoded from the state register: no registered delay, held stable until ack.
- Zero-wait memory timing (ack in strobe cycle):
  - 2 cycles per step without data access (IFETCH, STEP).
  - 3 cycles per step with data access.
- o_cpu_instr and o_cpu_din hold their values until overwritten.
- Simultaneous rd and wr from the CPU: write wins; no read is issued; o_cpu_din is unchanged.
- Timeout: the wait counter increments each cycle a strobe is high without ack and clears on state change.
  - When the counter reaches MAX_WAIT: drop the strobe, set o_bus_err, and load 0 into the target register.
  - Then advance as if ack had arrived, so the CPU still steps.
  - o_bus_err clears only on reset.
- i_clk_en low: never interrupts an access in progress; only blocks leaving IDLE/STEP.
- Reset mid-access: strobes drop asynchronously and the FSM returns to IDLE. The memory must tolerate aborted accesses.
- An ack received in IDLE or STEP is ignored.

Optional Feature:
- Macro IFETCH_HOLD_EN.
- When defined:
  - A valid bit plus last-fetched address register are kept.
  - On entering IFETCH with i_cpu_iaddr equal to the stored address and valid=1: no memory read is issued, the held instruction is reused, and the next state is chosen in the same cycle. This saves a cycle on CPU stall or self-loop steps.
  - valid clears on reset and on any write to the stored address.
- When undefined: every step performs a memory fetch.

Decomposition:
- Shared package/header (alongside the CPU's include):
  - State encodings: IDLE=2'd0, IFETCH=2'd1, DACC=2'd2, STEP=2'd3.
  - Default width constants.
- Sub-module mem_arb_wdog: the wait counter and timeout compare, with inputs strobe/ack/clear and output expired.

Test Plan:
- Zero-wait memory, i_clk_en=1, no data requests -> o_cpu_clk_en pulses every 2nd cycle; fetch addresses 0,1,2 yield o_cpu_instr = mem[0], mem[1], mem[2].
- Load at daddr 0x000100 holding 0xDEADBEEF, ack delayed 3 cycles -> o_mem_rd held 4 cycles with addr 0x000100; o_cpu_din=0xDEADBEEF at the STEP pulse.
- Store 0x12345678 to 0x000040 with rd=wr=1 -> single write strobe; mem[0x40]=0x12345678; no read issued.
- No ack for MAX_WAIT=4 -> strobe dropped after 4 cycles; o_bus_err=1; o_cpu_instr=0; CPU still steps.
- i_rstb low during DACC -> o_mem_rd/o_mem_wr fall immediately; after release, first access is an IFETCH.
- With IFETCH_HOLD_EN, iaddr repeated (0x10, 0x10) -> only one memory read; two STEP pulses; a store to 0x10 forces a refetch.

Source files
------------

// File: rtl/mem_arb_2432_pkg.sv
// Shared definitions for the mem_arb_2432 memory sequencer: state encoding,
// default widths and the watchdog counter sizing helper.
package mem_arb_2432_pkg;

  localparam int ADDR_W_DEF   = 24;
  localparam int DATA_W_DEF   = 32;
  localparam int INSTR_W_DEF  = 24;
  localparam int MAX_WAIT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2,
    STEP   = 2'd3
  } state_t;

  // Counter must be able to hold MAX_WAIT itself; keep at least one bit.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_arb_2432_wdog.sv
// Access watchdog: counts cycles a strobe waits for ack and flags expiry
// once MAX_WAIT cycles have elapsed; cleared whenever the sequencer changes state.
module mem_arb_wdog
  import mem_arb_2432_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic strobe,
  input  logic ack,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // Saturates at CNT_MAX so expiry stays asserted until the state moves on.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (strobe && !ack && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expired = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arb_2432.sv
// Single-port memory sequencer: instruction fetch, optional data access, then a
// one-cycle CPU advance pulse. Optional fetch reuse is enabled with IFETCH_HOLD_EN.
module mem_arb_2432
  import mem_arb_2432_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rstb,
  input  logic               i_clk_en,
  input  logic [ADDR_W-1:0]  i_cpu_iaddr,
  input  logic [ADDR_W-1:0]  i_cpu_daddr,
  input  logic [DATA_W-1:0]  i_cpu_dout,
  input  logic               i_cpu_ram_rd,
  input  logic               i_cpu_ram_wr,
  output logic [INSTR_W-1:0] o_cpu_instr,
  output logic [DATA_W-1:0]  o_cpu_din,
  output logic               o_cpu_clk_en,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_dout,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  input  logic [DATA_W-1:0]  i_mem_din,
  input  logic               i_mem_ack,
  output logic               o_bus_err
);

  state_t state_q, state_d;
  state_t after_fetch;

  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic [DATA_W-1:0]  din_q, din_nxt;
  logic               bus_err_q;

  logic data_req;
  logic access_req;
  logic expired;
  logic fetch_hit;
  logic instr_load;
  logic din_load;
  logic timeout_evt;
  logic fetch_done;
  logic fetch_fail;
  logic wr_done;

  assign data_req    = i_cpu_ram_rd | i_cpu_ram_wr;
  assign after_fetch = data_req ? DACC : STEP;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes, address and write data decode straight from the state register so
  // they rise in the first cycle of an access and drop asynchronously on reset.
  always_comb begin
    state_d      = state_q;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_addr   = '0;
    o_mem_dout   = '0;
    o_cpu_clk_en = 1'b0;
    access_req   = 1'b0;
    instr_load   = 1'b0;
    instr_nxt    = instr_q;
    din_load     = 1'b0;
    din_nxt      = din_q;
    timeout_evt  = 1'b0;
    fetch_done   = 1'b0;
    fetch_fail   = 1'b0;
    wr_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_clk_en) begin
          state_d = IFETCH;
        end
      end

      IFETCH: begin
        if (fetch_hit) begin
          state_d = after_fetch;
        end else begin
          access_req = 1'b1;
          o_mem_addr = i_cpu_iaddr;
          o_mem_rd   = !expired;
          if (expired) begin
            timeout_evt = 1'b1;
            fetch_fail  = 1'b1;
            instr_load  = 1'b1;
            instr_nxt   = '0;
            state_d     = after_fetch;
          end else if (i_mem_ack) begin
            fetch_done = 1'b1;
            instr_load = 1'b1;
            instr_nxt  = i_mem_din[INSTR_W-1:0];
            state_d    = after_fetch;
          end
        end
      end

      // A store takes priority when the CPU raises both requests.
      DACC: begin
        o_mem_addr = i_cpu_daddr;
        if (i_cpu_ram_wr) begin
          access_req = 1'b1;
          o_mem_wr   = !expired;
          o_mem_dout = i_cpu_dout;
          if (expired) begin
            timeout_evt = 1'b1;
            wr_done     = 1'b1;
            state_d     = STEP;
          end else if (i_mem_ack) begin
            wr_done = 1'b1;
            state_d = STEP;
          end
        end else if (i_cpu_ram_rd) begin
          access_req = 1'b1;
          o_mem_rd   = !expired;
          if (expired) begin
            timeout_evt = 1'b1;
            din_load    = 1'b1;
            din_nxt     = '0;
            state_d     = STEP;
          end else if (i_mem_ack) begin
            din_load = 1'b1;
            din_nxt  = i_mem_din;
            state_d  = STEP;
          end
        end else begin
          state_d = STEP;
        end
      end

      STEP: begin
        o_cpu_clk_en = 1'b1;
        state_d      = i_clk_en ? IFETCH : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mem_arb_wdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .strobe  (access_req),
    .ack     (i_mem_ack),
    .clear   (state_d != state_q),
    .expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      instr_q   <= '0;
      din_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (instr_load) begin
        instr_q <= instr_nxt;
      end
      if (din_load) begin
        din_q <= din_nxt;
      end
      if (timeout_evt) begin
        bus_err_q <= 1'b1;
      end
    end
  end

`ifdef IFETCH_HOLD_EN
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;

  assign fetch_hit = hold_valid && (i_cpu_iaddr == hold_addr);

  // A failed fetch or any store to the held address makes the copy stale.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
    end else begin
      if (fetch_done) begin
        hold_valid <= 1'b1;
        hold_addr  <= i_cpu_iaddr;
      end else if (fetch_fail) begin
        hold_valid <= 1'b0;
      end
      if (wr_done && (i_cpu_daddr == hold_addr)) begin
        hold_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_hold;

  assign fetch_hit   = 1'b0;
  assign unused_hold = fetch_done ^ fetch_fail ^ wr_done;
`endif

  assign o_cpu_instr = instr_q;
  assign o_cpu_din   = din_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arb_2432.sv
// Self-checking bench for mem_arb_2432: memory responder with programmable ack
// latency, directed scenarios and a randomized run against a step-level model.
module tb_mem_arb_2432;

  localparam int MW = 4;
`ifdef IFETCH_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        clk_en = 1'b0;
  logic [23:0] iaddr = '0;
  logic [23:0] daddr = '0;
  logic [31:0] cpu_dout = '0;
  logic        ram_rd = 1'b0;
  logic        ram_wr = 1'b0;
  logic [23:0] cpu_instr;
  logic [31:0] cpu_din;
  logic        cpu_clk_en;
  logic [23:0] mem_addr;
  logic [31:0] mem_dout;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_din;
  logic        mem_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_arb_2432 #(
    .ADDR_W(24), .DATA_W(32), .INSTR_W(24), .MAX_WAIT(MW)
  ) dut (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en),
    .i_cpu_iaddr(iaddr), .i_cpu_daddr(daddr), .i_cpu_dout(cpu_dout),
    .i_cpu_ram_rd(ram_rd), .i_cpu_ram_wr(ram_wr),
    .o_cpu_instr(cpu_instr), .o_cpu_din(cpu_din), .o_cpu_clk_en(cpu_clk_en),
    .o_mem_addr(mem_addr), .o_mem_dout(mem_dout), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .i_mem_din(mem_din), .i_mem_ack(mem_ack), .o_bus_err(bus_err)
  );

  // Memory responder state; mem and the counters are owned by the monitor block.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  bit          mem_ready = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        strobe_wait = 1'b0;
  logic        block_en = 1'b0;
  logic [23:0] block_addr = '0;
  logic [23:0] probe_addr = 24'hFFFFFF;
  int          n_rd = 0, n_wr = 0, probe_rd = 0, strobe_cycles = 0;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Step-level expectations carried between scenarios.
  logic [23:0] m_instr = '0;
  logic [31:0] m_din = '0;
  logic        m_hv = 1'b0;
  logic [23:0] m_ha = '0;

  assign mem_ack = (mem_rd | mem_wr) && !(block_en && mem_addr == block_addr) && (wait_cnt >= ack_delay);
  assign mem_din = mem[mem_addr[9:0]];

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 1024; a++) mem[a] = $urandom;
      mem_ready = 1'b1;
    end
    if (mem_rd | mem_wr) strobe_cycles++;
    if (mem_rd && mem_addr == probe_addr) probe_rd++;
    if (mem_rd && mem_ack) n_rd++;
    if (mem_wr && mem_ack) begin
      n_wr++;
      mem[mem_addr[9:0]] = mem_dout;
    end
  end

  always @(negedge clk) strobe_wait <= (mem_rd | mem_wr) && !mem_ack;
  always @(posedge clk) wait_cnt <= strobe_wait ? wait_cnt + 1 : 0;

  // Drives one CPU step and waits (bounded) for the advance pulse.
  task automatic run_step(input logic [23:0] ia, input logic [23:0] da, input logic rd,
                          input logic wr, input logic [31:0] dd, output int cyc, output bit found);
    clk_en = 1'b1; iaddr = ia; daddr = da; ram_rd = rd; ram_wr = wr; cpu_dout = dd;
    cyc = 0; found = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (cpu_clk_en) begin
        cyc = c; found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int s0;
    rstb = 1'b0; clk_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_instr !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 0", cpu_instr); end else n_pass++;
    n_checks++; if (cpu_din !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_din: got %h expected 0", cpu_din); end else n_pass++;
    n_checks++; if (cpu_clk_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clk_en: got %b expected 0", cpu_clk_en); end else n_pass++;
    n_checks++; if ({mem_rd, mem_wr} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 00", {mem_rd, mem_wr}); end else n_pass++;
    n_checks++; if (mem_addr !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end else n_pass++;
    n_checks++; if (mem_dout !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dout: got %h expected 0", mem_dout); end else n_pass++;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end else n_pass++;
    rstb = 1'b1;
    s0 = strobe_cycles;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (cpu_clk_en !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_pulse[%0d]: got %b expected 0", c, cpu_clk_en); end else n_pass++;
    end
    n_checks++; if (strobe_cycles !== s0) begin n_fail++; $display("[TB] FAIL idle_strobes: got %0d expected %0d", strobe_cycles - s0, 0); end else n_pass++;
  endtask

  task automatic test_fetch_seq();
    int cyc, r0; bit found; logic [23:0] e;
    ack_delay = 0;
    for (int k = 0; k < 3; k++) begin
      e = mem[k][23:0]; r0 = n_rd;
      run_step(24'(k), 24'h0, 1'b0, 1'b0, 32'h0, cyc, found);
      n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL fetch_pulse[%0d]: got none expected pulse", k); end else n_pass++;
      n_checks++; if (cpu_instr !== e) begin n_fail++; $display("[TB] FAIL fetch_instr[%0d]: got %h expected %h", k, cpu_instr, e); end else n_pass++;
      n_checks++; if (n_rd - r0 !== 1) begin n_fail++; $display("[TB] FAIL fetch_reads[%0d]: got %0d expected 1", k, n_rd - r0); end else n_pass++;
      if (k > 0) begin
        n_checks++; if (cyc !== 2) begin n_fail++; $display("[TB] FAIL fetch_cycles[%0d]: got %0d expected 2", k, cyc); end else n_pass++;
      end
      m_instr = e;
    end
    m_hv = 1'b1; m_ha = 24'h2;
  endtask

  task automatic test_load_wait();
    int cyc, p0; bit found; logic [23:0] e;
    run_step(24'h0A, 24'h100, 1'b0, 1'b1, 32'hDEADBEEF, cyc, found);
    n_checks++; if (mem[10'h100] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL preload_store: got %h expected deadbeef", mem[10'h100]); end else n_pass++;
    ack_delay = 3; probe_addr = 24'h100; p0 = probe_rd; e = mem[10'h0C][23:0];
    run_step(24'h0C, 24'h100, 1'b1, 1'b0, 32'h0, cyc, found);
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL load_pulse: got none expected pulse"); end else n_pass++;
    n_checks++; if (probe_rd - p0 !== 4) begin n_fail++; $display("[TB] FAIL load_rd_cycles: got %0d expected 4", probe_rd - p0); end else n_pass++;
    n_checks++; if (cpu_din !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL load_din: got %h expected deadbeef", cpu_din); end else n_pass++;
    n_checks++; if (cyc !== 9) begin n_fail++; $display("[TB] FAIL load_cycles: got %0d expected 9", cyc); end else n_pass++;
    n_checks++; if (cpu_instr !== e) begin n_fail++; $display("[TB] FAIL load_instr: got %h expected %h", cpu_instr, e); end else n_pass++;
    ack_delay = 0; m_instr = e; m_din = 32'hDEADBEEF; m_hv = 1'b1; m_ha = 24'h0C;
  endtask

  task automatic test_store_rdwr();
    int cyc, r0, w0, p0; bit found;
    probe_addr = 24'h40; r0 = n_rd; w0 = n_wr; p0 = probe_rd;
    run_step(24'h0B, 24'h40, 1'b1, 1'b1, 32'h12345678, cyc, found);
    n_checks++; if (n_wr - w0 !== 1) begin n_fail++; $display("[TB] FAIL store_writes: got %0d expected 1", n_wr - w0); end else n_pass++;
    n_checks++; if (n_rd - r0 !== 1) begin n_fail++; $display("[TB] FAIL store_reads: got %0d expected 1", n_rd - r0); end else n_pass++;
    n_checks++; if (probe_rd - p0 !== 0) begin n_fail++; $display("[TB] FAIL store_data_read: got %0d expected 0", probe_rd - p0); end else n_pass++;
    n_checks++; if (mem[10'h40] !== 32'h12345678) begin n_fail++; $display("[TB] FAIL store_mem: got %h expected 12345678", mem[10'h40]); end else n_pass++;
    n_checks++; if (cpu_din !== m_din) begin n_fail++; $display("[TB] FAIL store_din_kept: got %h expected %h", cpu_din, m_din); end else n_pass++;
    n_checks++; if (cyc !== 3) begin n_fail++; $display("[TB] FAIL store_cycles: got %0d expected 3", cyc); end else n_pass++;
    m_instr = mem[10'h0B][23:0]; m_hv = 1'b1; m_ha = 24'h0B;
  endtask

  task automatic test_hold();
    int cyc, r0, er, ec; bit found; logic [31:0] r, v;
    ack_delay = 2; r = mem[10'h10]; v = $urandom;
    for (int s = 0; s < 4; s++) begin
      r0 = n_rd;
      run_step(24'h10, 24'h10, 1'b0, (s == 2), v, cyc, found);
      case (s)
        0: begin er = 1; ec = 4; end
        1: begin er = HOLD ? 0 : 1; ec = HOLD ? 2 : 4; end
        2: begin er = HOLD ? 0 : 1; ec = HOLD ? 5 : 7; end
        default: begin er = 1; ec = 4; end
      endcase
      n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL hold_pulse[%0d]: got none expected pulse", s); end else n_pass++;
      n_checks++; if (n_rd - r0 !== er) begin n_fail++; $display("[TB] FAIL hold_reads[%0d]: got %0d expected %0d", s, n_rd - r0, er); end else n_pass++;
      n_checks++; if (cyc !== ec) begin n_fail++; $display("[TB] FAIL hold_cycles[%0d]: got %0d expected %0d", s, cyc, ec); end else n_pass++;
      n_checks++; if (cpu_instr !== ((s == 3) ? v[23:0] : r[23:0])) begin n_fail++; $display("[TB] FAIL hold_instr[%0d]: got %h expected %h", s, cpu_instr, (s == 3) ? v[23:0] : r[23:0]); end else n_pass++;
    end
    ack_delay = 0; m_instr = v[23:0]; m_hv = 1'b1; m_ha = 24'h10;
  endtask

  task automatic test_random();
    int cyc, r0, w0, d, er, ew, ec; bit found, hit;
    logic [23:0] ia, da, prev; logic rd, wr; logic [31:0] dd;
    for (int a = 0; a < 1024; a++) ref_mem[a] = mem[a];
    prev = 24'h0;
    for (int k = 0; k < 30; k++) begin
      ia = ($urandom_range(0, 1) == 0) ? prev : 24'($urandom_range(0, 7));
      da = 24'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); dd = $urandom;
      d = $urandom_range(0, 2); ack_delay = d;
      hit = HOLD && m_hv && (ia == m_ha);
      er = 0; ew = 0;
      if (hit) ec = 1;
      else begin ec = 1 + d; er++; m_instr = ref_mem[ia[9:0]][23:0]; m_hv = 1'b1; m_ha = ia; end
      if (wr) begin
        ref_mem[da[9:0]] = dd; ew++; ec += 1 + d;
        if (m_hv && m_ha == da) m_hv = 1'b0;
      end else if (rd) begin
        m_din = ref_mem[da[9:0]]; er++; ec += 1 + d;
      end
      ec += 1;
      r0 = n_rd; w0 = n_wr;
      run_step(ia, da, rd, wr, dd, cyc, found);
      n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL rand_pulse[%0d]: got none expected pulse", k); end else n_pass++;
      n_checks++; if (cpu_instr !== m_instr) begin n_fail++; $display("[TB] FAIL rand_instr[%0d]: got %h expected %h", k, cpu_instr, m_instr); end else n_pass++;
      n_checks++; if (cpu_din !== m_din) begin n_fail++; $display("[TB] FAIL rand_din[%0d]: got %h expected %h", k, cpu_din, m_din); end else n_pass++;
      n_checks++; if (cyc !== ec) begin n_fail++; $display("[TB] FAIL rand_cycles[%0d]: got %0d expected %0d", k, cyc, ec); end else n_pass++;
      n_checks++; if (n_rd - r0 !== er) begin n_fail++; $display("[TB] FAIL rand_reads[%0d]: got %0d expected %0d", k, n_rd - r0, er); end else n_pass++;
      n_checks++; if (n_wr - w0 !== ew) begin n_fail++; $display("[TB] FAIL rand_writes[%0d]: got %0d expected %0d", k, n_wr - w0, ew); end else n_pass++;
      prev = ia;
    end
    for (int a = 0; a < 8; a++) begin
      n_checks++; if (mem[a] !== ref_mem[a]) begin n_fail++; $display("[TB] FAIL rand_mem[%0d]: got %h expected %h", a, mem[a], ref_mem[a]); end else n_pass++;
    end
    ack_delay = 0;
  endtask

  task automatic test_timeout();
    int cyc, p0; bit found; logic [23:0] e;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("[TB] FAIL pre_timeout_err: got %b expected 0", bus_err); end else n_pass++;
    block_en = 1'b1; block_addr = 24'h50; probe_addr = 24'h50; p0 = probe_rd;
    run_step(24'h50, 24'h0, 1'b0, 1'b0, 32'h0, cyc, found);
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL timeout_pulse: got none expected pulse"); end else n_pass++;
    n_checks++; if (probe_rd - p0 !== MW) begin n_fail++; $display("[TB] FAIL timeout_strobe_cycles: got %0d expected %0d", probe_rd - p0, MW); end else n_pass++;
    n_checks++; if (cyc !== MW + 2) begin n_fail++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", cyc, MW + 2); end else n_pass++;
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err: got %b expected 1", bus_err); end else n_pass++;
    n_checks++; if (cpu_instr !== 24'h0) begin n_fail++; $display("[TB] FAIL timeout_instr: got %h expected 0", cpu_instr); end else n_pass++;
    block_en = 1'b0; e = mem[10'h51][23:0];
    run_step(24'h51, 24'h0, 1'b0, 1'b0, 32'h0, cyc, found);
    n_checks++; if (cpu_instr !== e) begin n_fail++; $display("[TB] FAIL post_timeout_instr: got %h expected %h", cpu_instr, e); end else n_pass++;
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("[TB] FAIL sticky_err: got %b expected 1", bus_err); end else n_pass++;
    n_checks++; if (cyc !== 2) begin n_fail++; $display("[TB] FAIL post_timeout_cycles: got %0d expected 2", cyc); end else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    block_en = 1'b1; block_addr = 24'h200;
    clk_en = 1'b1; iaddr = 24'h30; daddr = 24'h200; ram_rd = 1'b1; ram_wr = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 24'h200) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL rst_reach_dacc: got none expected data read"); end else n_pass++;
    #2 rstb = 1'b0;
    #1;
    n_checks++; if ({mem_rd, mem_wr} !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_strobes_drop: got %b expected 00", {mem_rd, mem_wr}); end else n_pass++;
    n_checks++; if (mem_addr !== 24'h0) begin n_fail++; $display("[TB] FAIL rst_addr: got %h expected 0", mem_addr); end else n_pass++;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_bus_err: got %b expected 0", bus_err); end else n_pass++;
    n_checks++; if (cpu_instr !== 24'h0) begin n_fail++; $display("[TB] FAIL rst_instr: got %h expected 0", cpu_instr); end else n_pass++;
    @(negedge clk);
    rstb = 1'b1; block_en = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_rd | mem_wr) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL rst_first_access: got none expected fetch"); end else n_pass++;
    n_checks++; if ({mem_rd, mem_wr} !== 2'b10) begin n_fail++; $display("[TB] FAIL rst_first_kind: got %b expected 10", {mem_rd, mem_wr}); end else n_pass++;
    n_checks++; if (mem_addr !== 24'h30) begin n_fail++; $display("[TB] FAIL rst_first_addr: got %h expected 000030", mem_addr); end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_load_wait();
    test_store_rdwr();
    test_hold();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
